ingredient_segmented: RTL and testbench
=======================================

// Module: ingredient_segmented
// PURPOSE
//  Parametrised successor to the single-piece falling ingredient. Piece is split into NUM_SEGS
//  segments that the chef presses by walking across it. It drops one floor once all are
//  pressed, or when a falling piece above hits it, and stops at the plate stack.
//  One instance per ingredient; sits between chef/map logic and the sprite renderer.
// PARAMETERS
//  X_START      10'd0    left edge X of the piece at reset (pixels)
//  Y_START      10'd0    top Y of the piece at reset (pixels)
//  NUM_SEGS     4        segment count, 1..8
//  SEG_W_LOG2   3        log2 of segment width in pixels (piece width = NUM_SEGS<<SEG_W_LOG2)
//  FOOT_OFS     10'd0    ChefY == BurgerY + FOOT_OFS means the chef stands on this piece's floor
//  FLOOR_PITCH  10'd48   vertical distance between floors (pixels)
//  FALL_STEP    10'd2    pixels moved per frame_clk while falling, >=1
//  HIT_GAP      10'd8    above piece within HIT_GAP above this piece's top counts as a hit
// PORTS
//  frame_clk        in   1          frame-rate clock; all state updates on posedge
//  Reset            in   1          synchronous, active-high
//  walk             in   1          chef is walking this frame
//  climb            in   1          chef is on a ladder this frame
//  ChefX            in   10         chef centre X (pixels)
//  ChefY            in   10         chef foot Y (pixels)
//  above_falling    in   1          piece directly above is falling
//  above_y          in   10         top Y of piece directly above
//  plate_top_y      in   10         current top of plate stack; lowest legal top Y for this piece
//  BurgerX          out  10         piece left edge X
//  BurgerY          out  10         piece top Y
//  seg_pressed      out  NUM_SEGS   per-segment pressed flags (renderer sags pressed segments)
//  falling          out  1          high while in FALL
//  land_pulse       out  1          one-cycle pulse on each landing (score / cascade hook)
//  finish           out  1          sticky: piece has landed on plate
// BEHAVIOUR
//  Reset: BurgerX=X_START, BurgerY=Y_START, state REST, seg_pressed=0, target=0,
//   falling=0, land_pulse=0, finish=0. Reset mid-fall returns to start position the next edge.
//  BurgerX is constant (pieces fall vertically). All coordinates are unsigned 10-bit.
//  States: REST -> FALL -> REST | DONE. DONE is terminal until Reset.
//  REST:
//   - on_piece = walk & !climb & ChefY==BurgerY+FOOT_OFS & BurgerX<=ChefX<BurgerX+(NUM_SEGS<<SEG_W_LOG2).
//   - on_piece: seg_pressed[(ChefX-BurgerX)>>SEG_W_LOG2] <= 1; flags are sticky while in REST.
//   - hit = above_falling & above_y+HIT_GAP >= BurgerY.
//   - go FALL when all NUM_SEGS flags would be set this cycle (incl. this cycle's press) OR hit.
//     Both true in the same cycle -> single transition, no double action.
//   - on entry: target <= min(BurgerY+FLOOR_PITCH, plate_top_y) (compare before clamp; no wrap).
//  FALL: falling=1; seg_pressed held all-ones for sprite; chef presses and hits ignored.
//   - each edge: if BurgerY+FALL_STEP >= target -> BurgerY<=target (clamp, never overshoot),
//     seg_pressed<=0, land_pulse=1 for that cycle;
//     next state DONE if target==plate_top_y else REST. Otherwise BurgerY<=BurgerY+FALL_STEP.
//  DONE: finish=1, falling=0, seg_pressed=0, position frozen; all inputs ignored.
//  Arrival in REST from FALL does not carry presses; chef standing there starts pressing next frame.
//  land_pulse: registered, high exactly one frame_clk cycle per landing, 0 otherwise.
//  plate_top_y changing during FALL does not retarget; target latched on FALL entry.
// TESTING
//  1 Reset, NUM_SEGS=4, SEG_W_LOG2=3, X_START=100, Y_START=50: BurgerX=100,BurgerY=50, all outputs 0.
//  2 Chef walks ChefX 100..131 on floor: seg_pressed 0001,0011,0111 -> FALL on 4th segment;
//    FLOOR_PITCH=48, FALL_STEP=2: BurgerY reaches 98 after 24 frames, land_pulse 1 cycle, REST.
//  3 Chef with climb=1 or ChefY off by 1 over piece: seg_pressed stays 0000, no fall.
//  4 above_falling=1, above_y=44, BurgerY=50, HIT_GAP=8: FALL next edge with seg_pressed=0 beforehand.
//  5 plate_top_y=80 from BurgerY=50, FALL_STEP=4: steps 54..78 then clamps to 80; finish=1 sticky,
//    further presses/hits ignored. FALL_STEP=3 from 50 to 98: lands at 98 exactly, no overshoot.
//  6 Reset asserted mid-FALL at BurgerY=70: next edge BurgerY=50, falling=0, seg_pressed=0.

Source files
------------

// File: rtl/ingredient_segmented.sv
`default_nettype none
// ============================================================================
// Module   : ingredient_segmented
// Purpose  : Segmented falling burger ingredient; pressed by the chef, drops a floor.
// Revision : 1.0 - initial release
// ============================================================================
module ingredient_segmented #(
   parameter logic [9:0] X_START     = 10'd0,
   parameter logic [9:0] Y_START     = 10'd0,
   parameter int         NUM_SEGS    = 4,
   parameter int         SEG_W_LOG2  = 3,
   parameter logic [9:0] FOOT_OFS    = 10'd0,
   parameter logic [9:0] FLOOR_PITCH = 10'd48,
   parameter logic [9:0] FALL_STEP   = 10'd2,
   parameter logic [9:0] HIT_GAP     = 10'd8
) (
   input  logic                frame_clk,
   input  logic                Reset,
   input  logic                walk,
   input  logic                climb,
   input  logic [9:0]          ChefX,
   input  logic [9:0]          ChefY,
   input  logic                above_falling,
   input  logic [9:0]          above_y,
   input  logic [9:0]          plate_top_y,
   output logic [9:0]          BurgerX,
   output logic [9:0]          BurgerY,
   output logic [NUM_SEGS-1:0] seg_pressed,
   output logic                falling,
   output logic                land_pulse,
   output logic                finish
);

   typedef enum logic [1:0] {
      ST_REST = 2'd0,
      ST_FALL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [10:0]         c_PIECE_W = 11'(NUM_SEGS << SEG_W_LOG2);
   localparam logic [NUM_SEGS-1:0] c_ALL     = {NUM_SEGS{1'b1}};

   state_t              r_state, w_state_n;
   logic [9:0]          r_y;
   logic [9:0]          r_target;
   logic [NUM_SEGS-1:0] r_seg;
   logic                r_land;

   logic [9:0]          w_rel;
   logic [9:0]          w_seg_idx;
   logic                w_on_piece;
   logic [NUM_SEGS-1:0] w_press_mask;
   logic                w_all;
   logic                w_hit;
   logic                w_go;
   logic [10:0]         w_y_pitch;
   logic [10:0]         w_y_step;
   logic [9:0]          w_target;
   logic                w_land;

   // All geometry sums are done one bit wider so nothing wraps at the screen edge.
   assign w_rel      = ChefX - X_START;
   assign w_seg_idx  = w_rel >> SEG_W_LOG2;
   assign w_on_piece = walk && !climb
                    && ({1'b0, ChefY} == ({1'b0, r_y} + {1'b0, FOOT_OFS}))
                    && (ChefX >= X_START)
                    && ({1'b0, ChefX} < ({1'b0, X_START} + c_PIECE_W));

   always_comb begin
      w_press_mask = '0;
      for (int i = 0; i < NUM_SEGS; i++) begin
         w_press_mask[i] = w_on_piece && (w_seg_idx == 10'(i));
      end
   end

   assign w_all     = &(r_seg | w_press_mask);
   assign w_hit     = above_falling && (({1'b0, above_y} + {1'b0, HIT_GAP}) >= {1'b0, r_y});
   assign w_go      = w_all || w_hit;
   assign w_y_pitch = {1'b0, r_y} + {1'b0, FLOOR_PITCH};
   assign w_target  = (w_y_pitch < {1'b0, plate_top_y}) ? w_y_pitch[9:0] : plate_top_y;
   assign w_y_step  = {1'b0, r_y} + {1'b0, FALL_STEP};
   assign w_land    = w_y_step >= {1'b0, r_target};

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         ST_REST: if (w_go) w_state_n = ST_FALL;
         ST_FALL: if (w_land) w_state_n = (r_target == plate_top_y) ? ST_DONE : ST_REST;
         ST_DONE: w_state_n = ST_DONE;
         default: w_state_n = ST_REST;
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         r_state  <= ST_REST;
         r_y      <= Y_START;
         r_target <= '0;
         r_seg    <= '0;
         r_land   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_land  <= 1'b0;
         case (r_state)
            ST_REST: begin
               if (w_go) begin
                  r_seg    <= c_ALL;
                  r_target <= w_target;
               end else begin
                  r_seg <= r_seg | w_press_mask;
               end
            end
            ST_FALL: begin
               if (w_land) begin
                  r_y    <= r_target;
                  r_seg  <= '0;
                  r_land <= 1'b1;
               end else begin
                  r_y <= w_y_step[9:0];
               end
            end
            default: r_seg <= '0;
         endcase
      end
   end

   assign BurgerX     = X_START;
   assign BurgerY     = r_y;
   assign seg_pressed = r_seg;
   assign falling     = (r_state == ST_FALL);
   assign land_pulse  = r_land;
   assign finish      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ingredient_segmented.sv
`default_nettype none
// ============================================================================
// Module   : tb_ingredient_segmented
// Purpose  : Directed vector bench for ingredient_segmented (three parameter sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ingredient_segmented;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       walk = 1'b0, climb = 1'b0;
   logic [9:0] cx = 10'd0, cy = 10'd0, ay = 10'd0;
   logic       af0 = 1'b0, af1 = 1'b0, af2 = 1'b0;

   logic [9:0] bx0, by0, bx1, by1, bx2, by2;
   logic [3:0] seg0, seg1, seg2;
   logic       fl0, lp0, fin0, fl1, lp1, fin1, fl2, lp2, fin2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ingredient_segmented #(.X_START(10'd100), .Y_START(10'd50), .FALL_STEP(10'd2)) u0 (
      .frame_clk(clk), .Reset(rst), .walk(walk), .climb(climb), .ChefX(cx), .ChefY(cy),
      .above_falling(af0), .above_y(ay), .plate_top_y(10'd400),
      .BurgerX(bx0), .BurgerY(by0), .seg_pressed(seg0), .falling(fl0),
      .land_pulse(lp0), .finish(fin0));

   ingredient_segmented #(.X_START(10'd300), .Y_START(10'd50), .FALL_STEP(10'd4)) u1 (
      .frame_clk(clk), .Reset(rst), .walk(walk), .climb(climb), .ChefX(cx), .ChefY(cy),
      .above_falling(af1), .above_y(ay), .plate_top_y(10'd80),
      .BurgerX(bx1), .BurgerY(by1), .seg_pressed(seg1), .falling(fl1),
      .land_pulse(lp1), .finish(fin1));

   ingredient_segmented #(.X_START(10'd300), .Y_START(10'd50), .FALL_STEP(10'd3)) u2 (
      .frame_clk(clk), .Reset(rst), .walk(walk), .climb(climb), .ChefX(cx), .ChefY(cy),
      .above_falling(af2), .above_y(ay), .plate_top_y(10'd400),
      .BurgerX(bx2), .BurgerY(by2), .seg_pressed(seg2), .falling(fl2),
      .land_pulse(lp2), .finish(fin2));

   typedef struct {
      logic       walk;
      logic       climb;
      logic [9:0] cx;
      logic [9:0] cy;
      logic       af;
      logic [9:0] ay;
      logic [3:0] seg;
      logic [9:0] y;
      logic       fall;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(logic w, logic c, int x, int y, logic a, int ayv,
                               logic [3:0] s, int ey, logic f);
      vec_t v;
      v.walk = w; v.climb = c; v.cx = 10'(x); v.cy = 10'(y);
      v.af = a; v.ay = 10'(ayv); v.seg = s; v.y = 10'(ey); v.fall = f;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = mk(1, 1, 100, 50, 0,  0, 4'b0000, 50, 0);   // climbing
      vecs[1]  = mk(1, 0, 100, 51, 0,  0, 4'b0000, 50, 0);   // foot one below
      vecs[2]  = mk(1, 0, 100, 49, 0,  0, 4'b0000, 50, 0);   // foot one above
      vecs[3]  = mk(0, 0, 100, 50, 0,  0, 4'b0000, 50, 0);   // standing, not walking
      vecs[4]  = mk(1, 0,  99, 50, 0,  0, 4'b0000, 50, 0);   // left of piece
      vecs[5]  = mk(1, 0, 132, 50, 0,  0, 4'b0000, 50, 0);   // right of piece
      vecs[6]  = mk(0, 0,   0,  0, 1, 41, 4'b0000, 50, 0);   // above too high: 49 < 50
      vecs[7]  = mk(0, 0,   0,  0, 0, 44, 4'b0000, 50, 0);   // close but not falling
      vecs[8]  = mk(1, 0, 100, 50, 0,  0, 4'b0001, 50, 0);
      vecs[9]  = mk(1, 0, 107, 50, 0,  0, 4'b0001, 50, 0);
      vecs[10] = mk(0, 0, 107, 50, 0,  0, 4'b0001, 50, 0);   // sticky
      vecs[11] = mk(1, 0, 108, 50, 0,  0, 4'b0011, 50, 0);
      vecs[12] = mk(1, 0, 116, 50, 0,  0, 4'b0111, 50, 0);
      vecs[13] = mk(1, 0, 131, 50, 0,  0, 4'b1111, 50, 1);   // last segment -> FALL
      vecs[14] = mk(1, 0, 100, 50, 0,  0, 4'b1111, 52, 1);   // presses ignored in FALL

      tick(); tick();
      chk("rst_bx", bx0, 100);
      chk("rst_by", by0, 50);
      chk("rst_seg", seg0, 0);
      chk("rst_fall", fl0, 0);
      chk("rst_land", lp0, 0);
      chk("rst_fin", fin0, 0);
      chk("rst_by_u1", by1, 50);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         walk = vecs[i].walk; climb = vecs[i].climb; cx = vecs[i].cx; cy = vecs[i].cy;
         af0 = vecs[i].af; ay = vecs[i].ay;
         tick();
         chk($sformatf("vec%0d_seg", i), seg0, vecs[i].seg);
         chk($sformatf("vec%0d_y", i), by0, vecs[i].y);
         chk($sformatf("vec%0d_fall", i), fl0, vecs[i].fall);
      end

      // Chef waits on the next floor; landing edge must not press.
      walk = 1'b1; cx = 10'd100; cy = 10'd98; af0 = 1'b0;
      for (int k = 2; k <= 23; k++) begin
         tick();
         chk($sformatf("fall2_y%0d", k), by0, 50 + 2 * k);
         chk($sformatf("fall2_lp%0d", k), lp0, 0);
      end
      tick();
      chk("land2_y", by0, 98);
      chk("land2_lp", lp0, 1);
      chk("land2_fall", fl0, 0);
      chk("land2_seg", seg0, 0);
      chk("land2_fin", fin0, 0);
      tick();
      chk("post2_lp", lp0, 0);
      chk("post2_seg", seg0, 4'b0001);
      walk = 1'b0;

      // Hit from above, then reset mid-fall.
      rst = 1'b1; tick(); rst = 1'b0;
      chk("hit_pre_seg", seg0, 0);
      chk("hit_pre_y", by0, 50);
      af0 = 1'b1; ay = 10'd44;
      tick();
      af0 = 1'b0;
      chk("hit_fall", fl0, 1);
      chk("hit_seg", seg0, 4'b1111);
      for (int k = 0; k < 10; k++) tick();
      chk("mid_y", by0, 70);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rstmid_y", by0, 50);
      chk("rstmid_fall", fl0, 0);
      chk("rstmid_seg", seg0, 0);

      // Plate clamp with FALL_STEP=4.
      af1 = 1'b1; ay = 10'd44;
      tick();
      af1 = 1'b0;
      chk("u1_fall", fl1, 1);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk($sformatf("u1_y%0d", k), by1, 50 + 4 * k);
      end
      tick();
      chk("u1_land_y", by1, 80);
      chk("u1_land_lp", lp1, 1);
      chk("u1_fin", fin1, 1);
      chk("u1_fall_off", fl1, 0);
      walk = 1'b1; cx = 10'd300; cy = 10'd80; af1 = 1'b1; ay = 10'd76;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("u1_done_fin%0d", k), fin1, 1);
         chk($sformatf("u1_done_y%0d", k), by1, 80);
         chk($sformatf("u1_done_seg%0d", k), seg1, 0);
         chk($sformatf("u1_done_lp%0d", k), lp1, 0);
         chk($sformatf("u1_done_fall%0d", k), fl1, 0);
      end
      chk("u1_bx", bx1, 300);
      walk = 1'b0; af1 = 1'b0;

      // FALL_STEP=3 lands exactly on the next floor.
      af2 = 1'b1; ay = 10'd44;
      tick();
      af2 = 1'b0;
      chk("u2_fall", fl2, 1);
      for (int k = 1; k <= 15; k++) begin
         tick();
         chk($sformatf("u2_y%0d", k), by2, 50 + 3 * k);
      end
      tick();
      chk("u2_land_y", by2, 98);
      chk("u2_land_lp", lp2, 1);
      chk("u2_fin", fin2, 0);
      chk("u2_fall_off", fl2, 0);
      tick();
      chk("u2_post_lp", lp2, 0);
      chk("u2_post_y", by2, 98);
      chk("u0_idle_y", by0, 50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
